// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with 3-sample majority vote and a one-word holding register.
// Latency: rx_empty falls on the UCLK edge after the final stop-bit sample tick.
// Backpressure: none on the line; a frame completing while the holding register is full is dropped and flags overrun_err.
//
// Ports: UCLK receive clock; reset_n async active-low reset; rx async serial input (idle high);
//   rd_uart pops the holding register and acknowledges the sticky error flags;
//   R_data/rx_empty holding register; frame_err/overrun_err sticky status; rx_busy frame in progress.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DIVISOR    = 54,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  UCLK,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  rd_uart,
  output logic [DATA_WIDTH-1:0] R_data,
  output logic                  rx_empty,
  output logic                  frame_err,
  output logic                  overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_WIDTH + 1);
  localparam int TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_SMP0 = SW'(OVERSAMPLE - 3);
  localparam logic [SW-1:0] S_SMP1 = SW'(OVERSAMPLE - 2);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(DIVISOR - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                state;
  logic                  rx_meta, rx_sync;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [SW-1:0]         s_cnt;
  logic [NW-1:0]         n_cnt;
  logic [1:0]            smp;
  logic                  maj;
  logic                  brk;
  logic [DATA_WIDTH-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit;
`endif

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge UCLK or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge UCLK or negedge reset_n) begin
    if (!reset_n)                tick_cnt <= '0;
    else if (tick_cnt == T_LAST) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = (tick_cnt == T_LAST);

  // Third vote is the live sample taken on the closing tick of the bit.
  assign maj = (smp[1] & smp[0]) | (smp[1] & rx_sync) | (smp[0] & rx_sync);

  always_ff @(posedge UCLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      smp         <= '0;
      brk         <= 1'b0;
      shreg       <= '0;
      R_data      <= '0;
      rx_empty    <= 1'b1;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      // Any read acknowledges the error flags; only a non-empty register is popped.
      // Frame completion below is written later so a same-cycle load wins.
      if (rd_uart) begin
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err  <= 1'b0;
`endif
        if (!rx_empty) rx_empty <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            state   <= S_START;
            s_cnt   <= '0;
            rx_busy <= 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            if (s_cnt == S_HALF) begin
              s_cnt <= '0;
              if (!rx_sync) begin
                state <= S_DATA;
                n_cnt <= '0;
              end else begin
                state   <= S_IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (s_cnt == S_SMP0) smp[1] <= rx_sync;
            if (s_cnt == S_SMP1) smp[0] <= rx_sync;
            if (s_cnt == S_LAST) begin
              shreg <= {maj, shreg[DATA_WIDTH-1:1]};
              s_cnt <= '0;
              n_cnt <= n_cnt + NW'(1);
              if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (s_cnt == S_SMP0) smp[1] <= rx_sync;
            if (s_cnt == S_SMP1) smp[0] <= rx_sync;
            if (s_cnt == S_LAST) begin
              par_bit <= maj;
              s_cnt   <= '0;
              state   <= S_STOP;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
`endif

        S_STOP: begin
          if (brk) begin
            // Break: wait for the line to return high so a held-low line is not read as a new start.
            if (rx_sync) begin
              brk     <= 1'b0;
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end else if (tick) begin
            if (s_cnt == S_SMP0) smp[1] <= rx_sync;
            if (s_cnt == S_SMP1) smp[0] <= rx_sync;
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              if (maj) begin
                state   <= S_IDLE;
                rx_busy <= 1'b0;
                if (rx_empty || rd_uart) begin
                  R_data   <= shreg;
                  rx_empty <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  if ((^shreg) != par_bit) parity_err <= 1'b1;
`endif
                end else begin
                  overrun_err <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                brk       <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against a transaction-level model of the holding register.
// Latency: model updates once per completed frame / read; per-cycle compare while outputs are settled.
// Backpressure: rd_uart driven by the bench only.
module tb_uart_rx_core;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int OS  = 16;
  localparam int BIT = DIV * OS;

  logic          UCLK    = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx      = 1'b1;
  logic          rd_uart = 1'b0;
  logic [DW-1:0] R_data;
  logic          rx_empty, frame_err, overrun_err, rx_busy;
  logic          perr_d;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  assign perr_d = parity_err;
`else
  assign perr_d = 1'b0;
`endif

  uart_rx_core #(.DATA_WIDTH(DW), .DIVISOR(DIV), .OVERSAMPLE(OS)) dut (
    .UCLK        (UCLK),
    .reset_n     (reset_n),
    .rx          (rx),
    .rd_uart     (rd_uart),
    .R_data      (R_data),
    .rx_empty    (rx_empty),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .rx_busy     (rx_busy)
  );

  always #5 UCLK = ~UCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model of what the host must see.
  logic [DW-1:0] m_data;
  logic          m_empty, m_ferr, m_oerr, m_perr, m_busy;
  logic          mon_on = 1'b0;
  logic [12:0]   dut_v, mdl_v;

  assign dut_v = {R_data, rx_empty, frame_err, overrun_err, rx_busy, perr_d};
  assign mdl_v = {m_data, m_empty, m_ferr, m_oerr, m_busy, m_perr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge UCLK) begin
    if (mon_on) check("monitor{data,empty,ferr,oerr,busy,perr}", 32'(dut_v), 32'(mdl_v));
  end

  task automatic model_reset();
    m_data = '0; m_empty = 1'b1; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_read();
    m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
    if (!m_empty) m_empty = 1'b1;
  endtask

  task automatic model_frame(input logic [DW-1:0] d, input logic stop_v, input bit par_ok);
    if (!stop_v) begin
      m_ferr = 1'b1;
    end else begin
      m_busy = 1'b0;
      if (m_empty) begin
        m_data  = d;
        m_empty = 1'b0;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) m_perr = 1'b1;
`endif
      end else begin
        m_oerr = 1'b1;
      end
    end
  endtask

  // Advance n clock cycles; returns 1 time unit after the last rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge UCLK);
      #1;
    end
  endtask

  task automatic do_read();
    rd_uart = 1'b1;
    cyc(1);
    rd_uart = 1'b0;
    model_read();
  endtask

  // One full frame; spike3 inverts the line for one tick over the middle vote of data bit 3.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_v, input bit bad_par, input bit spike3);
    logic par;
    bit   seen;
    par    = (^d) ^ bad_par;
    mon_on = 1'b0;
    rx     = 1'b0;
    cyc(8);
    m_busy = 1'b1;
    mon_on = 1'b1;
    cyc(BIT - 8);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      if (spike3 && i == 3) begin
        cyc(25);
        rx = ~d[i];
        cyc(4);
        rx = d[i];
        cyc(BIT - 29);
      end else begin
        cyc(BIT);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    cyc(BIT);
`endif
    mon_on = 1'b0;
    rx     = stop_v;
    seen   = 0;
    for (int c = 0; c < BIT; c++) begin
      cyc(1);
      // The word must be visible on the same edge the receiver goes idle.
      if (stop_v && !seen && !rx_busy) begin
        seen = 1;
        check("stop_edge_rx_empty", 32'(rx_empty), 32'h0);
      end
    end
    if (stop_v && !seen) check("stop_busy_drop", 32'(rx_busy), 32'h0);
    model_frame(d, stop_v, !bad_par);
    mon_on = 1'b1;
  endtask

  initial begin
    model_reset();
    cyc(3);
    check("rst_R_data",      32'(R_data),      32'h0);
    check("rst_rx_empty",    32'(rx_empty),    32'h1);
    check("rst_frame_err",   32'(frame_err),   32'h0);
    check("rst_overrun_err", 32'(overrun_err), 32'h0);
    check("rst_rx_busy",     32'(rx_busy),     32'h0);
    reset_n = 1'b1;
    cyc(4);
    mon_on = 1'b1;

    // Basic frame and pop.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("a5_R_data",      32'(R_data),      32'hA5);
    check("a5_rx_empty",    32'(rx_empty),    32'h0);
    check("a5_frame_err",   32'(frame_err),   32'h0);
    check("a5_overrun_err", 32'(overrun_err), 32'h0);
    do_read();
    check("a5_read_empty",  32'(rx_empty),    32'h1);
    check("a5_read_data",   32'(R_data),      32'hA5);
    do_read();
    check("empty_read_ignored_empty", 32'(rx_empty), 32'h1);
    check("empty_read_ignored_data",  32'(R_data),   32'hA5);
    cyc(10);

    // Glitch shorter than half a bit.
    mon_on = 1'b0;
    rx = 1'b0;
    cyc(8);
    check("glitch_busy_rise", 32'(rx_busy), 32'h1);
    cyc(8);
    rx = 1'b1;
    cyc(40);
    mon_on = 1'b1;
    check("glitch_busy_fall", 32'(rx_busy),   32'h0);
    check("glitch_rx_empty",  32'(rx_empty),  32'h1);
    check("glitch_frame_err", 32'(frame_err), 32'h0);

    // Overrun.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    cyc(10);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check("ovr_R_data",   32'(R_data),      32'h3C);
    check("ovr_flag",     32'(overrun_err), 32'h1);
    check("ovr_rx_empty", 32'(rx_empty),    32'h0);
    do_read();
    check("ovr_read_empty", 32'(rx_empty),    32'h1);
    check("ovr_read_flag",  32'(overrun_err), 32'h0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    check("post_ovr_R_data", 32'(R_data),      32'h11);
    check("post_ovr_empty",  32'(rx_empty),    32'h0);
    check("post_ovr_flag",   32'(overrun_err), 32'h0);
    do_read();
    cyc(10);

    // Bad stop bit followed by a break.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("brk_frame_err", 32'(frame_err), 32'h1);
    check("brk_rx_empty",  32'(rx_empty),  32'h1);
    cyc(300);
    check("brk_busy_held", 32'(rx_busy), 32'h1);
    mon_on = 1'b0;
    rx = 1'b1;
    cyc(8);
    m_busy = 1'b0;
    mon_on = 1'b1;
    cyc(700);
    check("brk_no_restart_empty", 32'(rx_empty),  32'h1);
    check("brk_no_restart_busy",  32'(rx_busy),   32'h0);
    check("brk_ferr_sticky",      32'(frame_err), 32'h1);
    do_read();
    check("brk_read_ferr", 32'(frame_err), 32'h0);
    cyc(10);

    // Reset in the middle of a frame, with an unread word present.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check("pre_rst_R_data", 32'(R_data), 32'h5A);
    cyc(10);
    mon_on = 1'b0;
    rx = 1'b0;
    cyc(5 * BIT);
    check("rstmid_busy", 32'(rx_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rstmid_R_data",   32'(R_data),      32'h0);
    check("rstmid_rx_empty", 32'(rx_empty),    32'h1);
    check("rstmid_busy_off", 32'(rx_busy),     32'h0);
    check("rstmid_ferr",     32'(frame_err),   32'h0);
    check("rstmid_oerr",     32'(overrun_err), 32'h0);
    model_reset();
    rx = 1'b1;
    cyc(4);
    reset_n = 1'b1;
    cyc(20);
    mon_on = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    check("post_rst_R_data", 32'(R_data),      32'h0F);
    check("post_rst_empty",  32'(rx_empty),    32'h0);
    check("post_rst_ferr",   32'(frame_err),   32'h0);
    check("post_rst_oerr",   32'(overrun_err), 32'h0);
    do_read();
    cyc(10);

    // One-tick spike on data bit 3 is outvoted.
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    check("spike_R_data", 32'(R_data), 32'h81);
    do_read();
    cyc(10);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("par_bad_R_data", 32'(R_data),     32'h07);
    check("par_bad_flag",   32'(parity_err), 32'h1);
    do_read();
    check("par_read_flag",  32'(parity_err), 32'h0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    check("par_good_R_data", 32'(R_data),     32'h03);
    check("par_good_flag",   32'(parity_err), 32'h0);
    do_read();
    cyc(10);
`endif

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
